// File: rtl/processor_pkg.sv
// Shared definitions for the five-stage pipelined core: opcodes, instruction
// layout and decode helpers used by the hazard and writeback logic.
package processor_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned REG_AW   = 4;
   localparam int unsigned NUM_REGS = 16;

   typedef enum logic [3:0] {
      OP_HLT = 4'd0, OP_MOV, OP_MVI, OP_LOD, OP_STR, OP_ADD, OP_SUB, OP_MUL,
      OP_AND, OP_ORR, OP_NOT, OP_LES, OP_GTR, OP_JEZ, OP_JNZ, OP_JMP
   } opcode_e;

   // [31:28] opcode, [27:24] rd, [23:20] ra, [19:16] rb, [15:0] imm
   typedef struct packed {
      opcode_e           op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] ra;
      logic [REG_AW-1:0] rb;
      logic [15:0]       imm;
   } instr_t;

   function automatic logic reads_ra(input opcode_e op);
      return op inside {OP_MOV, OP_LOD, OP_STR, OP_ADD, OP_SUB, OP_MUL,
                        OP_AND, OP_ORR, OP_NOT, OP_LES, OP_GTR};
   endfunction

   function automatic logic reads_rb(input opcode_e op);
      return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_ORR, OP_LES, OP_GTR};
   endfunction

   function automatic logic reads_rd(input opcode_e op);
      return op inside {OP_STR, OP_JEZ, OP_JNZ};
   endfunction

   function automatic logic writes_rd(input opcode_e op);
      return op inside {OP_MOV, OP_MVI, OP_LOD, OP_ADD, OP_SUB, OP_MUL,
                        OP_AND, OP_ORR, OP_NOT, OP_LES, OP_GTR};
   endfunction

endpackage

// File: rtl/register_file.sv
// 16-entry register file: three decode read ports with write-first bypass,
// one debug read port, one write port, synchronous clear on reset.
// Ports: i_clock, i_reset_n (sync, active-low), i_we/i_waddr/i_wdata write port,
//        i_ra/rb/rd_addr -> o_ra/rb/rd_data_c, i_dbg_addr -> o_dbg_data_c.
module register_file
   import processor_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_ra_addr,
   input  logic [REG_AW-1:0] i_rb_addr,
   input  logic [REG_AW-1:0] i_rd_addr,
   input  logic [REG_AW-1:0] i_dbg_addr,
   output logic [DATA_W-1:0] o_ra_data_c,
   output logic [DATA_W-1:0] o_rb_data_c,
   output logic [DATA_W-1:0] o_rd_data_c,
   output logic [DATA_W-1:0] o_dbg_data_c
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_regs <= '{default: '0};
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Same-cycle writeback is visible to decode
   assign o_ra_data_c  = (i_we && (i_waddr == i_ra_addr)) ? i_wdata : r_regs[i_ra_addr];
   assign o_rb_data_c  = (i_we && (i_waddr == i_rb_addr)) ? i_wdata : r_regs[i_rb_addr];
   assign o_rd_data_c  = (i_we && (i_waddr == i_rd_addr)) ? i_wdata : r_regs[i_rd_addr];
   assign o_dbg_data_c = r_regs[i_dbg_addr];

endmodule

// File: rtl/pipelined_processor.sv
// Five-stage (IF, ID, EX, MA, WB) single-clock core with EX forwarding,
// load-use interlock, branch/halt flushing and internal I/D memories.
// Ports: clock, reset_n (sync, active-low); imem_we/imem_waddr/imem_wdata load
//        port; dbg_raddr -> dbg_rdata (combinational register read); pc fetch PC;
//        halted (HLT has left WB); retired_count (valid WB slots, wraps).
module pipelined_processor
   import processor_pkg::*;
#(
   parameter  int unsigned DATA_W     = 32,
   parameter  int unsigned IMEM_DEPTH = 1024,
   parameter  int unsigned DMEM_DEPTH = 1024,
   localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH),
   localparam int unsigned DMEM_AW    = $clog2(DMEM_DEPTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               imem_we,
   input  logic [IMEM_AW-1:0] imem_waddr,
   input  logic [INSTR_W-1:0] imem_wdata,
   input  logic [REG_AW-1:0]  dbg_raddr,
   output logic [DATA_W-1:0]  dbg_rdata,
   output logic [IMEM_AW-1:0] pc,
   output logic               halted,
   output logic [31:0]        retired_count
);

   logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0]  r_dmem [DMEM_DEPTH];

   logic [IMEM_AW-1:0] r_pc;
   logic               r_halt_pend;
   logic               r_halted;
   logic [31:0]        r_retired;

   logic               r_ifid_valid;
   instr_t             r_ifid_instr;
   logic [IMEM_AW-1:0] r_ifid_pc;

   logic               r_idex_valid;
   instr_t             r_idex_instr;
   logic [IMEM_AW-1:0] r_idex_pc;
   logic [DATA_W-1:0]  r_idex_a, r_idex_b, r_idex_d;

   logic               r_exma_valid;
   opcode_e            r_exma_op;
   logic [REG_AW-1:0]  r_exma_rd;
   logic [DATA_W-1:0]  r_exma_res, r_exma_sdata;

   logic               r_mawb_valid;
   opcode_e            r_mawb_op;
   logic [REG_AW-1:0]  r_mawb_rd;
   logic [DATA_W-1:0]  r_mawb_res;

   logic [DATA_W-1:0]  w_id_a, w_id_b, w_id_d;
   logic [DATA_W-1:0]  w_op_a, w_op_b, w_op_d, w_imm, w_ex_res, w_ma_res;
   logic [IMEM_AW-1:0] w_target;
   logic [DMEM_AW-1:0] w_mem_addr;
   logic               w_exma_fwd, w_mawb_fwd, w_wb_we;
   logic               w_taken, w_halt_ex, w_stall, w_flush;

   register_file #(.DATA_W(DATA_W)) u_regfile (
      .i_clock      (clock),
      .i_reset_n    (reset_n),
      .i_we         (w_wb_we),
      .i_waddr      (r_mawb_rd),
      .i_wdata      (r_mawb_res),
      .i_ra_addr    (r_ifid_instr.ra),
      .i_rb_addr    (r_ifid_instr.rb),
      .i_rd_addr    (r_ifid_instr.rd),
      .i_dbg_addr   (dbg_raddr),
      .o_ra_data_c  (w_id_a),
      .o_rb_data_c  (w_id_b),
      .o_rd_data_c  (w_id_d),
      .o_dbg_data_c (dbg_rdata)
   );

   assign w_imm      = DATA_W'($signed(r_idex_instr.imm));
   assign w_exma_fwd = r_exma_valid && writes_rd(r_exma_op) && (r_exma_op != OP_LOD);
   assign w_mawb_fwd = r_mawb_valid && writes_rd(r_mawb_op);
   assign w_wb_we    = r_mawb_valid && writes_rd(r_mawb_op);

   // Operand forwarding; the younger EX/MA producer overrides MA/WB
   always_comb begin
      w_op_a = r_idex_a;
      w_op_b = r_idex_b;
      w_op_d = r_idex_d;
      if (w_mawb_fwd && (r_mawb_rd == r_idex_instr.ra)) w_op_a = r_mawb_res;
      if (w_mawb_fwd && (r_mawb_rd == r_idex_instr.rb)) w_op_b = r_mawb_res;
      if (w_mawb_fwd && (r_mawb_rd == r_idex_instr.rd)) w_op_d = r_mawb_res;
      if (w_exma_fwd && (r_exma_rd == r_idex_instr.ra)) w_op_a = r_exma_res;
      if (w_exma_fwd && (r_exma_rd == r_idex_instr.rb)) w_op_b = r_exma_res;
      if (w_exma_fwd && (r_exma_rd == r_idex_instr.rd)) w_op_d = r_exma_res;
   end

   // EX result; for LOD/STR it is the data-memory address
   always_comb begin
      w_ex_res = '0;
      case (r_idex_instr.op)
         OP_MOV:         w_ex_res = w_op_a;
         OP_MVI:         w_ex_res = w_imm;
         OP_LOD, OP_STR: w_ex_res = w_op_a + w_imm;
         OP_ADD:         w_ex_res = w_op_a + w_op_b;
         OP_SUB:         w_ex_res = w_op_a - w_op_b;
         OP_MUL:         w_ex_res = w_op_a * w_op_b;
         OP_AND:         w_ex_res = w_op_a & w_op_b;
         OP_ORR:         w_ex_res = w_op_a | w_op_b;
         OP_NOT:         w_ex_res = ~w_op_a;
         OP_LES:         w_ex_res = DATA_W'(w_op_a < w_op_b);
         OP_GTR:         w_ex_res = DATA_W'(w_op_a > w_op_b);
         default:        w_ex_res = '0;
      endcase
   end

   assign w_taken   = r_idex_valid && ((r_idex_instr.op == OP_JMP) ||
                      ((r_idex_instr.op == OP_JEZ) && (w_op_d == '0)) ||
                      ((r_idex_instr.op == OP_JNZ) && (w_op_d != '0)));
   assign w_target  = r_idex_pc + IMEM_AW'($signed(r_idex_instr.imm));
   assign w_halt_ex = r_idex_valid && (r_idex_instr.op == OP_HLT);
   assign w_flush   = w_taken || w_halt_ex || r_halt_pend;

   // Load-use: the loaded value is only available from MA/WB onward
   assign w_stall = r_ifid_valid && r_idex_valid && (r_idex_instr.op == OP_LOD) &&
                    ((reads_ra(r_ifid_instr.op) && (r_ifid_instr.ra == r_idex_instr.rd)) ||
                     (reads_rb(r_ifid_instr.op) && (r_ifid_instr.rb == r_idex_instr.rd)) ||
                     (reads_rd(r_ifid_instr.op) && (r_ifid_instr.rd == r_idex_instr.rd)));

   assign w_mem_addr = DMEM_AW'(r_exma_res);
   assign w_ma_res   = (r_exma_op == OP_LOD) ? r_dmem[w_mem_addr] : r_exma_res;

   // Instruction memory load port, independent of reset
   always_ff @(posedge clock) begin
      if (imem_we) r_imem[imem_waddr] <= imem_wdata;
   end

   // Data memory store in MA; contents survive reset
   always_ff @(posedge clock) begin
      if (reset_n && r_exma_valid && (r_exma_op == OP_STR)) r_dmem[w_mem_addr] <= r_exma_sdata;
   end

   // Pipeline registers, PC and status
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_pc         <= '0;
         r_halt_pend  <= 1'b0;
         r_halted     <= 1'b0;
         r_retired    <= '0;
         r_ifid_valid <= 1'b0;
         r_idex_valid <= 1'b0;
         r_exma_valid <= 1'b0;
         r_mawb_valid <= 1'b0;
      end else begin
         // IF: redirect, freeze after HLT, hold on interlock, else fetch
         if (w_taken) begin
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
         end else if (w_halt_ex || r_halt_pend) begin
            r_ifid_valid <= 1'b0;
         end else if (!w_stall) begin
            r_pc         <= r_pc + IMEM_AW'(1);
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= instr_t'(r_imem[r_pc]);
            r_ifid_pc    <= r_pc;
         end
         if (w_halt_ex) r_halt_pend <= 1'b1;

         // ID -> EX
         r_idex_valid <= r_ifid_valid && !w_flush && !w_stall;
         r_idex_instr <= r_ifid_instr;
         r_idex_pc    <= r_ifid_pc;
         r_idex_a     <= w_id_a;
         r_idex_b     <= w_id_b;
         r_idex_d     <= w_id_d;

         // EX -> MA
         r_exma_valid <= r_idex_valid;
         r_exma_op    <= r_idex_instr.op;
         r_exma_rd    <= r_idex_instr.rd;
         r_exma_res   <= w_ex_res;
         r_exma_sdata <= w_op_d;

         // MA -> WB
         r_mawb_valid <= r_exma_valid;
         r_mawb_op    <= r_exma_op;
         r_mawb_rd    <= r_exma_rd;
         r_mawb_res   <= w_ma_res;

         // WB retirement
         if (r_mawb_valid) r_retired <= r_retired + 32'd1;
         if (r_mawb_valid && (r_mawb_op == OP_HLT)) r_halted <= 1'b1;
      end
   end

   assign pc            = r_pc;
   assign halted        = r_halted;
   assign retired_count = r_retired;

endmodule
